// File: rtl/wb_block_master_if.sv
// rtl/wb_block_master_if.sv - Wishbone classic initiator/target bundle
interface wb_block_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_block_master.sv
// rtl/wb_block_master.sv - Wishbone classic block-transfer initiator
module wb_block_master #(
    parameter int LEN_WIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [LEN_WIDTH-1:0] cmd_len_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [31:0]          wr_data_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [31:0]          rd_data_o,
    wb_block_master_if.master    wbm,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDATA = 3'd1;
    localparam logic [2:0] S_BUS   = 3'd2;
    localparam logic [2:0] S_RHOLD = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]           state;
    logic                 run_q;
    logic                 we_q;
    logic                 cyc_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdat_q;
    logic [LEN_WIDTH-1:0] rem_q;
    logic [TW-1:0]        tcnt_q;
    logic                 rd_valid_q;
    logic [31:0]          rd_data_q;
    logic                 done_q;
    logic                 err_q;
    logic                 cmd_fire;

    // run_q keeps cmd_ready low for the first cycle after reset release
    assign cmd_ready_o = (state == S_IDLE) && run_q;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign wr_ready_o  = (state == S_WDATA);
    assign busy_o      = (state != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = cyc_q && we_q;
    assign wbm.wbm_sel_o = {4{cyc_q}};
    assign wbm.wbm_adr_o = addr_q;
    assign wbm.wbm_dat_o = wdat_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            run_q      <= 1'b0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdat_q     <= 32'h0;
            rem_q      <= '0;
            tcnt_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        we_q   <= cmd_we_i;
                        addr_q <= cmd_addr_i & 32'hFFFF_FFFC;
                        rem_q  <= cmd_len_i;
                        if (cmd_len_i == '0) begin
                            state <= S_FIN;
                        end else if (cmd_we_i) begin
                            state <= S_WDATA;
                        end else begin
                            state  <= S_BUS;
                            cyc_q  <= 1'b1;
                            tcnt_q <= '0;
                        end
                    end
                end
                S_WDATA: begin
                    if (wr_valid_i) begin
                        wdat_q <= wr_data_i;
                        state  <= S_BUS;
                        cyc_q  <= 1'b1;
                        tcnt_q <= '0;
                    end
                end
                S_BUS: begin
                    // ack takes priority over a timeout expiring in the same cycle
                    if (wbm.wbm_ack_i) begin
                        cyc_q <= 1'b0;
                        if (we_q) begin
                            state <= S_GAP;
                        end else begin
                            rd_data_q  <= wbm.wbm_dat_i;
                            rd_valid_q <= 1'b1;
                            state      <= S_RHOLD;
                        end
                    end else if (tcnt_q == T_LAST) begin
                        cyc_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_RHOLD: begin
                    if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    rem_q  <= rem_q - LEN_WIDTH'(1);
                    addr_q <= addr_q + 32'd4;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state <= S_FIN;
                    end else if (we_q) begin
                        state <= S_WDATA;
                    end else begin
                        state  <= S_BUS;
                        cyc_q  <= 1'b1;
                        tcnt_q <= '0;
                    end
                end
                S_FIN: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    cyc_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_block_master.sv
// tb/tb_wb_block_master.sv - directed bench for wb_block_master
module tb_wb_block_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [7:0]  cmd_len = 8'h0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = 32'h0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;

    wb_block_master_if bus();

    wb_block_master #(.LEN_WIDTH(8), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .wbm(bus),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    // target model: ack after ack_delay stalled strobe cycles
    bit          ack_en = 1'b0;
    int          ack_delay = 0;
    int          stb_cnt = 0;
    int          rd_idx = 0;
    int          rd_base = 0;
    logic [31:0] rd_mem [8];

    assign bus.wbm_ack_i = ack_en && bus.wbm_stb_o && (stb_cnt == ack_delay);
    assign bus.wbm_dat_i = rd_mem[3'(rd_idx - rd_base)];

    always @(posedge clk) begin
        if (bus.wbm_stb_o && !bus.wbm_ack_i) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
        if (bus.wbm_stb_o && bus.wbm_ack_i) rd_idx <= rd_idx + 1;
    end

    // observation log, sampled on the falling edge
    int          n_beats = 0, n_strobes = 0, n_stb_cyc = 0, idle_cnt = 0;
    int          n_done = 0, n_err = 0, n_rdv = 0, n_rx = 0, done_rx = 0;
    int          unstable = 0, rd_unstable = 0;
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic [3:0]  log_sel [64];
    logic        log_we  [64];
    int          gaps    [64];
    logic [31:0] rx      [64];
    logic        prev_stb = 1'b0, prev_rdv = 1'b0, prev_rdy = 1'b0;
    logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0, prev_rdd = 32'h0;

    always @(negedge clk) begin
        n_done    <= n_done + int'(done);
        n_err     <= n_err + int'(err);
        n_rdv     <= n_rdv + int'(rd_valid);
        n_stb_cyc <= n_stb_cyc + int'(bus.wbm_stb_o);
        idle_cnt  <= bus.wbm_stb_o ? 0 : idle_cnt + 1;
        if (bus.wbm_stb_o && !prev_stb) begin
            gaps[6'(n_strobes)] <= idle_cnt;
            n_strobes <= n_strobes + 1;
        end
        if (bus.wbm_stb_o && bus.wbm_ack_i) begin
            log_adr[6'(n_beats)] <= bus.wbm_adr_o;
            log_dat[6'(n_beats)] <= bus.wbm_we_o ? bus.wbm_dat_o : bus.wbm_dat_i;
            log_sel[6'(n_beats)] <= bus.wbm_sel_o;
            log_we[6'(n_beats)]  <= bus.wbm_we_o;
            n_beats <= n_beats + 1;
        end
        if (bus.wbm_stb_o && prev_stb && (bus.wbm_adr_o != prev_adr || bus.wbm_dat_o != prev_dat))
            unstable <= unstable + 1;
        if (rd_valid && prev_rdv && !prev_rdy && rd_data != prev_rdd)
            rd_unstable <= rd_unstable + 1;
        if (rd_valid && rd_ready) begin
            rx[6'(n_rx)] <= rd_data;
            n_rx <= n_rx + 1;
        end
        if (done) done_rx <= n_rx;
        prev_stb <= bus.wbm_stb_o;
        prev_adr <= bus.wbm_adr_o;
        prev_dat <= bus.wbm_dat_o;
        prev_rdv <= rd_valid;
        prev_rdy <= rd_ready;
        prev_rdd <= rd_data;
    end

    logic [31:0] wr_words [8];
    int          wi = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit wh;
        wh = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        if (wh) begin
            wi++;
            wr_data = wr_words[3'(wi)];
        end
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("cmd_accept_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        check(tag, 32'(busy), 32'h0);
        tick();
        tick();
    endtask

    int b0, s0, c0, d0, e0, v0, r0, n;

    initial begin
        for (int i = 0; i < 8; i++) begin wr_words[i] = 32'h0; rd_mem[i] = 32'h0; end

        // reset state
        tick(); tick(); tick();
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
        check("rst_stb", 32'(bus.wbm_stb_o), 32'h0);
        check("rst_adr", bus.wbm_adr_o, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // 1: reset asserted mid-BUS of a 4-word write
        ack_en = 1'b0;
        wr_words[0] = 32'h1; wi = 0; wr_data = 32'h1; wr_valid = 1'b1;
        send_cmd(1'b1, 32'h0000_1000, 8'd4);
        n = 0;
        while (!bus.wbm_stb_o && n < 20) begin tick(); n++; end
        check("t1_stb_up", 32'(bus.wbm_stb_o), 32'h1);
        tick(); tick();
        wr_valid = 1'b0;
        d0 = n_done; e0 = n_err;
        #2 rst_n = 1'b0;
        #1;
        check("t1_cyc_async", 32'(bus.wbm_cyc_o), 32'h0);
        check("t1_stb_async", 32'(bus.wbm_stb_o), 32'h0);
        check("t1_busy_async", 32'(busy), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("t1_no_done", 32'(n_done - d0), 32'h0);
        check("t1_no_err", 32'(n_err - e0), 32'h0);
        check("t1_cmd_ready", 32'(cmd_ready), 32'h1);

        // 2: write len=3, ack on 2nd strobe cycle
        ack_en = 1'b1; ack_delay = 1;
        wr_words[0] = 32'hA1; wr_words[1] = 32'hB2; wr_words[2] = 32'hC3;
        wi = 0; wr_data = 32'hA1; wr_valid = 1'b1;
        b0 = n_beats; s0 = n_strobes; c0 = n_stb_cyc; d0 = n_done; e0 = n_err;
        send_cmd(1'b1, 32'h30C0_0010, 8'd3);
        wait_idle("t2_finish");
        wr_valid = 1'b0;
        check("t2_beats", 32'(n_beats - b0), 32'd3);
        check("t2_strobes", 32'(n_strobes - s0), 32'd3);
        check("t2_stb_cycles", 32'(n_stb_cyc - c0), 32'd6);
        check("t2_adr0", log_adr[6'(b0)], 32'h30C0_0010);
        check("t2_adr1", log_adr[6'(b0 + 1)], 32'h30C0_0014);
        check("t2_adr2", log_adr[6'(b0 + 2)], 32'h30C0_0018);
        check("t2_dat0", log_dat[6'(b0)], 32'hA1);
        check("t2_dat1", log_dat[6'(b0 + 1)], 32'hB2);
        check("t2_dat2", log_dat[6'(b0 + 2)], 32'hC3);
        check("t2_sel0", 32'(log_sel[6'(b0)]), 32'hF);
        check("t2_sel2", 32'(log_sel[6'(b0 + 2)]), 32'hF);
        check("t2_we1", 32'(log_we[6'(b0 + 1)]), 32'h1);
        check("t2_gap1", 32'(gaps[6'(s0 + 1)] >= 1), 32'h1);
        check("t2_gap2", 32'(gaps[6'(s0 + 2)] >= 1), 32'h1);
        check("t2_done", 32'(n_done - d0), 32'd1);
        check("t2_no_err", 32'(n_err - e0), 32'h0);
        check("t2_stable", 32'(unstable), 32'h0);

        // 3: read len=2 with a stalled consumer
        ack_delay = 0;
        rd_mem[0] = 32'h1111_1111; rd_mem[1] = 32'h2222_2222; rd_base = rd_idx;
        rd_ready = 1'b0;
        b0 = n_beats; s0 = n_strobes; d0 = n_done; r0 = n_rx;
        send_cmd(1'b0, 32'h30C0_0000, 8'd2);
        n = 0;
        while (!rd_valid && n < 30) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", 32'(rd_valid), 32'h1);
            check("t3_hold_data", rd_data, 32'h1111_1111);
            check("t3_hold_no_stb", 32'(bus.wbm_stb_o), 32'h0);
            tick();
        end
        check("t3_one_strobe", 32'(n_strobes - s0), 32'd1);
        rd_ready = 1'b1;
        wait_idle("t3_finish");
        check("t3_beats", 32'(n_beats - b0), 32'd2);
        check("t3_adr0", log_adr[6'(b0)], 32'h30C0_0000);
        check("t3_adr1", log_adr[6'(b0 + 1)], 32'h30C0_0004);
        check("t3_rx0", rx[6'(r0)], 32'h1111_1111);
        check("t3_rx1", rx[6'(r0 + 1)], 32'h2222_2222);
        check("t3_done", 32'(n_done - d0), 32'd1);
        check("t3_done_after_2nd", 32'(done_rx - r0), 32'd2);
        check("t3_rd_stable", 32'(rd_unstable), 32'h0);

        // 4: zero-length command
        c0 = n_stb_cyc;
        send_cmd(1'b0, 32'h0000_0040, 8'd0);
        check("t4_done_c1", 32'(done), 32'h0);
        check("t4_busy_c1", 32'(busy), 32'h1);
        tick();
        check("t4_done_c2", 32'(done), 32'h1);
        tick();
        check("t4_done_c3", 32'(done), 32'h0);
        check("t4_busy_c3", 32'(busy), 32'h0);
        check("t4_no_stb", 32'(n_stb_cyc - c0), 32'h0);

        // 5: read len=4, target never acks
        ack_en = 1'b0;
        s0 = n_strobes; c0 = n_stb_cyc; d0 = n_done; e0 = n_err; v0 = n_rdv;
        send_cmd(1'b0, 32'h0000_2000, 8'd4);
        wait_idle("t5_finish");
        check("t5_stb_cycles", 32'(n_stb_cyc - c0), 32'd16);
        check("t5_strobes", 32'(n_strobes - s0), 32'd1);
        check("t5_err", 32'(n_err - e0), 32'd1);
        check("t5_no_done", 32'(n_done - d0), 32'h0);
        check("t5_no_rd_valid", 32'(n_rdv - v0), 32'h0);

        // 6: address wrap, ack coincident with last timeout cycle
        ack_en = 1'b1; ack_delay = 15; rd_ready = 1'b1;
        rd_mem[0] = 32'hCAFE_0001; rd_mem[1] = 32'hCAFE_0002; rd_base = rd_idx;
        b0 = n_beats; c0 = n_stb_cyc; d0 = n_done; e0 = n_err; r0 = n_rx;
        send_cmd(1'b0, 32'hFFFF_FFFC, 8'd2);
        wait_idle("t6_finish");
        check("t6_beats", 32'(n_beats - b0), 32'd2);
        check("t6_adr0", log_adr[6'(b0)], 32'hFFFF_FFFC);
        check("t6_adr1_wrap", log_adr[6'(b0 + 1)], 32'h0000_0000);
        check("t6_stb_cycles", 32'(n_stb_cyc - c0), 32'd32);
        check("t6_rx0", rx[6'(r0)], 32'hCAFE_0001);
        check("t6_rx1", rx[6'(r0 + 1)], 32'hCAFE_0002);
        check("t6_no_err", 32'(n_err - e0), 32'h0);
        check("t6_done", 32'(n_done - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
